// File: rtl/tx_frame_sched.sv
// Round-robin scheduler sharing one serial frame transmitter among four byte
// requesters, with loop-back check, timeout and bounded retransmission.
//
// state   | meaning
// S_IDLE  | waiting for a request; arbitrate and capture the winning byte
// S_LOAD  | pulse tx_en to start a frame
// S_SEND  | frame on the serial line for FRAME_LEN clocks
// S_CHECK | wait up to TMO clocks for the receiver verdict
// S_GAP   | idle gap, then resend (retry pending) or return to idle
module tx_frame_sched #(
  parameter int FRAME_LEN = 10,
  parameter int GAP       = 2,
  parameter int TMO       = 4,
  parameter int MAX_RETRY = 2
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic [3:0]  req_i,
  input  logic [31:0] din_i,
  output logic [3:0]  ack_o,
  output logic [3:0]  done_o,
  output logic [3:0]  fail_o,
  output logic [7:0]  tx_data_o,
  output logic        tx_en_o,
  input  logic        rx_ro_i,
  input  logic        rx_per_i,
  output logic        busy_o
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SEND, S_CHECK, S_GAP} state_t;

  localparam logic [3:0] FRAME_LAST = 4'(FRAME_LEN - 1);
  localparam logic [2:0] GAP_LAST   = 3'(GAP - 1);
  localparam logic [2:0] TMO_LAST   = 3'(TMO - 1);
  localparam logic [1:0] RETRY_MAX  = 2'(MAX_RETRY);

  state_t      state_q;
  logic [1:0]  rr_q, owner_q, retry_q;
  logic [3:0]  frame_cnt_q;
  logic [2:0]  gap_cnt_q, tmo_cnt_q;
  logic        retry_flag_q;
  logic [3:0]  ack_q, done_q, fail_q;
  logic [7:0]  tx_data_q;
  logic        tx_en_q, busy_q;

  logic        gnt_vld_d;
  logic [1:0]  gnt_idx_d, scan_idx_d;

  // First requester at or after rr_q, wrapping 3 -> 0.
  always_comb begin
    gnt_vld_d  = 1'b0;
    gnt_idx_d  = rr_q;
    scan_idx_d = rr_q;
    for (int k = 0; k < 4; k++) begin
      scan_idx_d = rr_q + 2'(k);
      if (!gnt_vld_d && req_i[scan_idx_d]) begin
        gnt_vld_d = 1'b1;
        gnt_idx_d = scan_idx_d;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q      <= S_IDLE;
      rr_q         <= 2'd0;
      owner_q      <= 2'd0;
      retry_q      <= 2'd0;
      frame_cnt_q  <= 4'd0;
      gap_cnt_q    <= 3'd0;
      tmo_cnt_q    <= 3'd0;
      retry_flag_q <= 1'b0;
      ack_q        <= 4'd0;
      done_q       <= 4'd0;
      fail_q       <= 4'd0;
      tx_data_q    <= 8'd0;
      tx_en_q      <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      ack_q   <= 4'd0;
      done_q  <= 4'd0;
      fail_q  <= 4'd0;
      tx_en_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (gnt_vld_d) begin
            ack_q        <= 4'b0001 << gnt_idx_d;
            tx_data_q    <= din_i[{gnt_idx_d, 3'b000} +: 8];
            owner_q      <= gnt_idx_d;
            retry_q      <= 2'd0;
            retry_flag_q <= 1'b0;
            rr_q         <= gnt_idx_d + 2'd1;
            busy_q       <= 1'b1;
            state_q      <= S_LOAD;
          end
        end
        S_LOAD: begin
          tx_en_q     <= 1'b1;
          frame_cnt_q <= FRAME_LAST;
          state_q     <= S_SEND;
        end
        S_SEND: begin
          if (frame_cnt_q == 4'd0) begin
            tmo_cnt_q <= TMO_LAST;
            state_q   <= S_CHECK;
          end else begin
            frame_cnt_q <= frame_cnt_q - 4'd1;
          end
        end
        S_CHECK: begin
          if (rx_ro_i && !rx_per_i) begin
            done_q       <= 4'b0001 << owner_q;
            retry_flag_q <= 1'b0;
            gap_cnt_q    <= GAP_LAST;
            state_q      <= S_GAP;
          end else if (rx_ro_i || tmo_cnt_q == 3'd0) begin
            gap_cnt_q <= GAP_LAST;
            state_q   <= S_GAP;
            if (retry_q < RETRY_MAX) begin
              retry_q      <= retry_q + 2'd1;
              retry_flag_q <= 1'b1;
            end else begin
              fail_q       <= 4'b0001 << owner_q;
              retry_flag_q <= 1'b0;
            end
          end else begin
            tmo_cnt_q <= tmo_cnt_q - 3'd1;
          end
        end
        S_GAP: begin
          if (gap_cnt_q == 3'd0) begin
            if (retry_flag_q) begin
              state_q <= S_LOAD;
            end else begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            gap_cnt_q <= gap_cnt_q - 3'd1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign ack_o     = ack_q;
  assign done_o    = done_q;
  assign fail_o    = fail_q;
  assign tx_data_o = tx_data_q;
  assign tx_en_o   = tx_en_q;
  assign busy_o    = busy_q;

endmodule

// File: tb/tb_tx_frame_sched.sv
// Directed plus randomized bench for tx_frame_sched against a transaction-level
// model of arbitration order, attempt timing and retry outcome.
module tb_tx_frame_sched;
  localparam int FRAME_LEN = 10;
  localparam int GAP       = 2;
  localparam int TMO       = 4;
  localparam int MAX_RETRY = 2;
  localparam int M_GOOD = 0, M_PERR = 1, M_TMO = 2;

  logic        clk_i = 1'b0;
  logic        rstn_i;
  logic [3:0]  req_i;
  logic [31:0] din_i;
  logic        rx_ro_i, rx_per_i;
  logic [3:0]  ack_o, done_o, fail_o;
  logic [7:0]  tx_data_o;
  logic        tx_en_o, busy_o;

  tx_frame_sched #(.FRAME_LEN(FRAME_LEN), .GAP(GAP), .TMO(TMO), .MAX_RETRY(MAX_RETRY)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .req_i(req_i), .din_i(din_i),
    .ack_o(ack_o), .done_o(done_o), .fail_o(fail_o),
    .tx_data_o(tx_data_o), .tx_en_o(tx_en_o),
    .rx_ro_i(rx_ro_i), .rx_per_i(rx_per_i), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  int n_chk = 0, n_pass = 0;
  int cyc = 0, en_cnt = 0, done_cnt = 0, fail_cnt = 0;
  int rr = 0, cur_g = 0, retries = 0, last_ack = 0;
  logic [7:0] cur_byte = 8'd0;

  always @(posedge clk_i) begin
    cyc++;
    if (tx_en_o) en_cnt++;
    if (done_o != 4'd0) done_cnt++;
    if (fail_o != 4'd0) fail_cnt++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout observed=running required=finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(negedge clk_i);
  endtask

  function automatic int pick(input logic [3:0] r, input int p);
    for (int k = 0; k < 4; k++)
      if (r[(p + k) % 4]) return (p + k) % 4;
    return 0;
  endfunction

  // Leaves the bench at the negedge where tx_en of the first attempt is expected.
  task automatic start_frame(input logic [3:0] r, input logic [31:0] d);
    int w;
    req_i = r;
    din_i = d;
    cur_g = pick(r, rr);
    cur_byte = d[8*cur_g +: 8];
    tick();
    w = 0;
    while (ack_o === 4'd0 && w < 20) begin
      tick();
      w++;
    end
    chk("ack", ack_o, 32'(1 << cur_g));
    chk("tx_data_at_ack", tx_data_o, cur_byte);
    rr = (cur_g + 1) % 4;
    last_ack = cyc;
    retries = 0;
    tick();
  endtask

  task automatic attempt(input int mode, input int dly, input bit noise, output bit fin);
    int  e_off;
    bit  quiet;
    logic [3:0] exp_done, exp_fail;
    chk("tx_en_start", tx_en_o, 1);
    chk("tx_data_frame", tx_data_o, cur_byte);
    e_off = (mode == M_TMO) ? (FRAME_LEN + TMO) : (FRAME_LEN + 1 + dly);
    quiet = 1'b1;
    for (int c = 1; c <= e_off; c++) begin
      rx_ro_i = 1'b0;
      rx_per_i = 1'b0;
      if (noise && c == 2) begin
        rx_ro_i = 1'b1;
        rx_per_i = 1'($urandom_range(0, 1));
      end
      if (c == e_off && mode != M_TMO) begin
        rx_ro_i = 1'b1;
        rx_per_i = (mode == M_PERR);
      end
      tick();
      if (c < e_off)
        quiet &= (tx_en_o === 1'b0 && done_o === 4'd0 && fail_o === 4'd0 &&
                  ack_o === 4'd0 && busy_o === 1'b1);
    end
    chk("quiet_in_frame", quiet, 1);
    exp_done = 4'd0;
    exp_fail = 4'd0;
    if (mode == M_GOOD) begin
      exp_done = 4'(1 << cur_g);
      fin = 1'b1;
    end else if (retries < MAX_RETRY) begin
      retries++;
      fin = 1'b0;
    end else begin
      exp_fail = 4'(1 << cur_g);
      fin = 1'b1;
    end
    chk("done", done_o, exp_done);
    chk("fail", fail_o, exp_fail);
    rx_ro_i = noise;
    rx_per_i = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    tick();
    rx_ro_i = 1'b0;
    rx_per_i = 1'b0;
    chk("gap_quiet", {busy_o, done_o, fail_o, tx_en_o}, 32'h200);
    tick();
    chk("busy_after_gap", busy_o, !fin);
    if (!fin) begin
      chk("no_ack_on_retry", ack_o, 0);
      tick();
    end
  endtask

  task automatic run_frame(input logic [3:0] r, input logic [31:0] d,
                           input int m0, input int m1, input int m2,
                           input int dly, input bit noise);
    int modes[3];
    int exp_att, en0, dn0, fl0;
    bit good, fin;
    modes[0] = m0; modes[1] = m1; modes[2] = m2;
    exp_att = MAX_RETRY + 1;
    good = 1'b0;
    for (int i = 0; i <= MAX_RETRY; i++)
      if (!good && modes[i] == M_GOOD) begin
        good = 1'b1;
        exp_att = i + 1;
      end
    en0 = en_cnt; dn0 = done_cnt; fl0 = fail_cnt;
    start_frame(r, d);
    fin = 1'b0;
    for (int a = 0; a <= MAX_RETRY && !fin; a++)
      attempt(modes[a], dly, noise, fin);
    chk("tx_en_count", en_cnt - en0, exp_att);
    chk("done_count", done_cnt - dn0, good ? 1 : 0);
    chk("fail_count", fail_cnt - fl0, good ? 0 : 1);
  endtask

  initial begin
    int prev;
    rstn_i = 1'b0;
    req_i = 4'd0;
    din_i = 32'd0;
    rx_ro_i = 1'b0;
    rx_per_i = 1'b0;
    #2;
    chk("reset_outputs", {ack_o, done_o, fail_o, tx_data_o, tx_en_o, busy_o}, 0);
    tick();
    tick();
    rstn_i = 1'b1;
    tick();
    chk("idle_no_req", {ack_o, busy_o}, 0);

    // single request from requester 1
    run_frame(4'b0010, 32'h1234_A5CD, M_GOOD, M_GOOD, M_GOOD, 1, 1'b0);
    chk("tx_data_hold", tx_data_o, 8'hA5);

    // wrap: serve 2, then 1001 gives 3 then 0
    run_frame(4'b0100, $urandom, M_GOOD, M_GOOD, M_GOOD, 0, 1'b0);
    run_frame(4'b1001, $urandom, M_GOOD, M_GOOD, M_GOOD, 2, 1'b1);
    chk("wrap_grant3", cur_g, 3);
    run_frame(4'b1001, $urandom, M_GOOD, M_GOOD, M_GOOD, 3, 1'b0);
    chk("wrap_grant0", cur_g, 0);

    // parity error then success
    run_frame(4'b0100, $urandom, M_PERR, M_GOOD, M_GOOD, 1, 1'b1);
    // timeouts exhaust all retries
    run_frame(4'b1000, $urandom, M_TMO, M_TMO, M_TMO, 0, 1'b0);
    // mixed failures exhausting retries
    run_frame(4'b0011, $urandom, M_PERR, M_TMO, M_PERR, 2, 1'b1);

    // reset in the middle of SEND
    prev = done_cnt + fail_cnt;
    start_frame(4'b0110, $urandom);
    req_i = 4'd0;
    for (int i = 0; i < 4; i++) tick();
    rstn_i = 1'b0;
    #1;
    chk("reset_mid_send", {ack_o, done_o, fail_o, tx_data_o, tx_en_o, busy_o}, 0);
    tick();
    rstn_i = 1'b1;
    rr = 0;
    for (int i = 0; i < 20; i++) tick();
    chk("aborted_no_outcome", done_cnt + fail_cnt, prev);
    chk("idle_after_abort", busy_o, 0);

    // round robin with all requests held, back-to-back frames
    for (int i = 0; i < 5; i++) begin
      prev = last_ack;
      run_frame(4'b1111, $urandom, M_GOOD, M_GOOD, M_GOOD, 0, 1'b0);
      chk("rr_order", cur_g, i % 4);
      if (i > 0) chk("ack_spacing", last_ack - prev, 15);
    end

    // randomized traffic
    for (int i = 0; i < 8; i++)
      run_frame(4'($urandom_range(1, 15)), $urandom,
                $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2),
                $urandom_range(0, TMO - 1), 1'($urandom_range(0, 1)));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
